mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit. Consumes the M-stage control signals emitted by the EX/MEM control pipe
//  (memwrite_m, result_src_m, load_sel_m, store_sel_m) plus ALU address/store data, and runs a req/ack data-bus
//  transaction. Stalls the pipeline until the access completes, then presents sign/zero-extended load data to MEM/WB.
//  Flags misaligned accesses and bus timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles in WAIT without mem_ack before abort with bus_err (>=2)
//  CNT_W           5   width of timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
//  Clk              in   1   rising-edge clock
//  Rst_n            in   1   synchronous active-low reset
//  memwrite_m       in   1   store in M stage
//  result_src_m     in   2   2'b01 = load (result from memory); other values = no load
//  load_sel_m       in   2   00 LW, 01 LH, 10 LB, 11 treated as LW
//  load_unsigned_m  in   1   1 = zero-extend (LBU/LHU); ignored for LW
//  store_sel_m      in   3   001 SB, 010 SH, 100 SW; other values = no store (even if memwrite_m)
//  alu_addr_m       in   32  byte address
//  store_data_m     in   32  rs2 value, LSB-aligned
//  stall_m          out  1   hold IF..M stages
//  load_data_m      out  32  extended load result to MEM/WB
//  load_valid_m     out  1   one-cycle pulse: load_data_m valid
//  misalign_err     out  1   one-cycle pulse: misaligned access rejected
//  bus_err          out  1   one-cycle pulse: timeout abort
//  mem_req          out  1   bus request, registered
//  mem_we           out  1   1 = write, registered
//  mem_addr         out  32  word-aligned address {addr[31:2],2'b00}, registered
//  mem_be           out  4   byte enables, registered
//  mem_wdata        out  32  lane-replicated store data, registered
//  mem_ack          in   1   bus completes transfer this cycle
//  mem_rdata        in   32  read word, valid with mem_ack
// BEHAVIOUR
//  Reset (Rst_n=0 at edge): state=IDLE, counter=0; all outputs 0. Mid-transaction reset drops mem_req next edge.
//  access = (memwrite_m & store_sel_m valid) | (result_src_m==2'b01). A store takes priority if both are set.
//  Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No bus cycle; misalign_err pulses the next cycle.
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE
//   IDLE: on aligned access, stall_m=1 combinationally. Latch op/addr/data/lane controls and drive mem_* at the edge. -> REQ
//   REQ : mem_req=1, stall_m=1. If mem_ack -> DONE, else -> WAIT with counter cleared.
//   WAIT: mem_req held, stall_m=1, counter++ each cycle. mem_ack -> DONE.
//         If counter reaches TIMEOUT_CYCLES-1 with no ack: drop mem_req, pulse bus_err, force load_data_m=0, -> DONE.
//   DONE: stall_m=0 so the pipeline advances. mem_req=0. Inputs are ignored because they belong to the completed op. -> IDLE.
//  mem_* outputs stay stable while mem_req=1. mem_req is deasserted the edge after mem_ack is sampled.
//  Back-to-back accesses: one IDLE cycle between DONE and the next REQ (min 3 cycles/access).
//  Lanes (a=addr[1:0]):
//   SB: be=1<<a, wdata={4{d[7:0]}}
//   SH: be=a[1]?1100:0011, wdata={2{d[15:0]}}
//   SW: be=1111, wdata=d
//   Loads: be=1111, mem_we=0.
//  Load data is registered on the ack edge, valid in DONE with the load_valid_m pulse, and held until the next load completes.
//   LB/LBU selects byte a; LH/LHU selects half a[1]. Sign- or zero-extend to 32 bits per load_unsigned_m.
//  Stores never pulse load_valid_m. bus_err on a load also pulses load_valid_m with data 0.
// TESTING
//  1. SW addr 0x100, data 0xDEADBEEF, ack on REQ cycle -> mem_addr 0x100, be 1111, wdata 0xDEADBEEF; stall 2 cycles, drop in DONE.
//  2. LB addr 0x203, rdata 0x80112233 ack after 3 WAIT -> load_data_m 0xFFFFFF80, load_valid 1 pulse; LBU same -> 0x00000080.
//  3. SH addr 0x102, data 0x0000ABCD -> be 1100, wdata 0xABCDABCD; LH addr 0x101 -> misalign_err pulse, mem_req never 1, no stall.
//  4. LW, mem_ack held 0 -> mem_req drops and bus_err+load_valid pulse after TIMEOUT_CYCLES in WAIT, load_data_m 0.
//  5. Rst_n=0 during WAIT -> next edge mem_req 0, stall_m 0, all outputs 0; a late mem_ack is ignored.
//  6. Back-to-back SB 0x3 (data 0x55) then LH 0x2 -> be 1000 / wdata 0x55555555, then IDLE gap, then load with be 1111.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns M-stage load/store controls into a
// registered req/ack bus transaction, stalls until it completes, and extends load data.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        memwrite_m,
  input  logic [1:0]  result_src_m,
  input  logic [1:0]  load_sel_m,
  input  logic        load_unsigned_m,
  input  logic [2:0]  store_sel_m,
  input  logic [31:0] alu_addr_m,
  input  logic [31:0] store_data_m,
  output logic        stall_m,
  output logic [31:0] load_data_m,
  output logic        load_valid_m,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // S_IDLE | waiting for an M-stage access; misaligned ones are rejected here
  // S_REQ  | first bus cycle, ack may arrive immediately
  // S_WAIT | holding the request, timeout counter running
  // S_DONE | access retired, pipeline released for one cycle
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_load;
  logic [1:0]        op_size;
  logic              op_unsigned;
  logic [1:0]        op_off;

  logic              store_ok;
  logic              access;
  logic              misaligned;
  logic [1:0]        size_next;
  logic [3:0]        be_next;
  logic [31:0]       wdata_next;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       ext_data;

  assign store_ok = memwrite_m &
                    ((store_sel_m == 3'b001) | (store_sel_m == 3'b010) | (store_sel_m == 3'b100));
  assign access   = store_ok | (result_src_m == 2'b01);

  always_comb begin
    size_next  = SZ_WORD;
    be_next    = 4'b1111;
    wdata_next = 32'h0;
    if (store_ok) begin
      case (store_sel_m)
        3'b001: begin
          size_next  = SZ_BYTE;
          be_next    = 4'b0001 << alu_addr_m[1:0];
          wdata_next = {4{store_data_m[7:0]}};
        end
        3'b010: begin
          size_next  = SZ_HALF;
          be_next    = alu_addr_m[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{store_data_m[15:0]}};
        end
        default: wdata_next = store_data_m;
      endcase
    end else begin
      case (load_sel_m)
        2'b01:   size_next = SZ_HALF;
        2'b10:   size_next = SZ_BYTE;
        default: size_next = SZ_WORD;
      endcase
    end
  end

  assign misaligned = ((size_next == SZ_HALF) & alu_addr_m[0]) |
                      ((size_next == SZ_WORD) & (alu_addr_m[1:0] != 2'b00));

  // Held in reset the unit must not stall, even if the stage still shows an access.
  assign stall_m = (state == S_REQ) | (state == S_WAIT) |
                   ((state == S_IDLE) & Rst_n & access & ~misaligned);

  always_comb begin
    case (op_off)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_size)
      SZ_BYTE: ext_data = op_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: ext_data = op_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ext_data = mem_rdata;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op_load      <= 1'b0;
      op_size      <= SZ_WORD;
      op_unsigned  <= 1'b0;
      op_off       <= 2'b00;
      load_data_m  <= 32'h0;
      load_valid_m <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_be       <= 4'h0;
      mem_wdata    <= 32'h0;
    end else begin
      load_valid_m <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (misaligned) begin
              misalign_err <= 1'b1;
            end else begin
              mem_req     <= 1'b1;
              mem_we      <= store_ok;
              mem_addr    <= {alu_addr_m[31:2], 2'b00};
              mem_be      <= be_next;
              mem_wdata   <= wdata_next;
              op_load     <= ~store_ok;
              op_size     <= size_next;
              op_unsigned <= load_unsigned_m;
              op_off      <= alu_addr_m[1:0];
              state       <= S_REQ;
            end
          end
        end
        S_REQ, S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (op_load) begin
              load_data_m  <= ext_data;
              load_valid_m <= 1'b1;
            end
            state <= S_DONE;
          end else if (state == S_REQ) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (op_load) begin
              load_data_m  <= 32'h0;
              load_valid_m <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected bus requests and load results are
// queued as each access is driven and popped when the DUT presents them.
module tb_mem_access_unit;

  localparam int TIMEOUT_CYCLES = 16;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        memwrite_m;
  logic [1:0]  result_src_m;
  logic [1:0]  load_sel_m;
  logic        load_unsigned_m;
  logic [2:0]  store_sel_m;
  logic [31:0] alu_addr_m;
  logic [31:0] store_data_m;
  logic        stall_m;
  logic [31:0] load_data_m;
  logic        load_valid_m;
  logic        misalign_err;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .memwrite_m(memwrite_m), .result_src_m(result_src_m), .load_sel_m(load_sel_m),
    .load_unsigned_m(load_unsigned_m), .store_sel_m(store_sel_m),
    .alu_addr_m(alu_addr_m), .store_data_m(store_data_m),
    .stall_m(stall_m), .load_data_m(load_data_m), .load_valid_m(load_valid_m),
    .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
  } ld_exp_t;

  bus_exp_t    bus_q[$];
  ld_exp_t     ld_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_load = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    memwrite_m      = 1'b0;
    result_src_m    = 2'b00;
    load_sel_m      = 2'b00;
    load_unsigned_m = 1'b0;
    store_sel_m     = 3'b000;
    alu_addr_m      = 32'h0;
    store_data_m    = 32'h0;
  endtask

  function automatic logic [3:0] m_be(input logic st, input logic [2:0] ssel, input logic [1:0] a);
    if (!st) return 4'b1111;
    case (ssel)
      3'b001: case (a)
                2'd0: return 4'b0001;
                2'd1: return 4'b0010;
                2'd2: return 4'b0100;
                default: return 4'b1000;
              endcase
      3'b010: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] ssel, input logic [31:0] d);
    case (ssel)
      3'b001:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b010:  return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lsel,
                                         input logic uns, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (lsel)
      2'b10:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Drives one aligned access from IDLE and follows it to the following IDLE cycle.
  // ack_delay = number of WAIT cycles before ack (0 = ack in REQ); to = never ack.
  task automatic do_access(input string tag, input logic st_en, input logic [2:0] ssel,
                           input logic [1:0] rsrc, input logic [1:0] lsel, input logic uns,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int ack_delay, input bit to);
    logic     is_store, is_load;
    bus_exp_t be_e;
    ld_exp_t  ld_e;
    is_store = st_en && (ssel == 3'b001 || ssel == 3'b010 || ssel == 3'b100);
    is_load  = !is_store && (rsrc == 2'b01);
    memwrite_m = st_en; store_sel_m = ssel; result_src_m = rsrc; load_sel_m = lsel;
    load_unsigned_m = uns; alu_addr_m = addr; store_data_m = data;
    bus_q.push_back('{tag, is_store, {addr[31:2], 2'b00}, m_be(is_store, ssel, addr[1:0]),
                      m_wdata(ssel, data)});
    if (is_load)
      ld_q.push_back('{tag, to ? 32'h0 : m_load(rdata, lsel, uns, addr[1:0]), to});
    #1;
    chk({tag, "_idle_stall"}, 32'(stall_m), 32'd1);
    chk({tag, "_idle_req"}, 32'(mem_req), 32'd0);
    tick();
    be_e = bus_q.pop_front();
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_req_stall"}, 32'(stall_m), 32'd1);
    chk({tag, "_we"}, 32'(mem_we), 32'(be_e.we));
    chk({tag, "_addr"}, mem_addr, be_e.addr);
    chk({tag, "_be"}, 32'(mem_be), 32'(be_e.be));
    if (is_store) chk({tag, "_wdata"}, mem_wdata, be_e.wdata);
    if (to) begin
      for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
        tick();
        chk({tag, "_to_hold"}, {30'h0, mem_req, bus_err}, 32'd2);
      end
    end else begin
      for (int i = 0; i < ack_delay; i++) begin
        tick();
        chk({tag, "_wait"}, {30'h0, mem_req, stall_m}, 32'd3);
        chk({tag, "_wait_addr"}, mem_addr, be_e.addr);
      end
      mem_ack = 1'b1;
      mem_rdata = rdata;
    end
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'hx;
    chk({tag, "_done_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_done_stall"}, 32'(stall_m), 32'd0);
    chk({tag, "_done_berr"}, 32'(bus_err), 32'(to));
    chk({tag, "_done_lv"}, 32'(load_valid_m), 32'(is_load));
    if (is_load) begin
      ld_e = ld_q.pop_front();
      chk({tag, "_ldata"}, load_data_m, ld_e.data);
      last_load = ld_e.data;
    end else begin
      chk({tag, "_ldata_held"}, load_data_m, last_load);
    end
    tick();
    chk({tag, "_gap_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_gap_lv"}, 32'(load_valid_m), 32'd0);
  endtask

  task automatic misalign(input string tag, input logic st_en, input logic [2:0] ssel,
                          input logic [1:0] rsrc, input logic [1:0] lsel, input logic [31:0] addr);
    memwrite_m = st_en; store_sel_m = ssel; result_src_m = rsrc; load_sel_m = lsel;
    alu_addr_m = addr;
    #1;
    chk({tag, "_stall"}, 32'(stall_m), 32'd0);
    tick();
    chk({tag, "_err"}, 32'(misalign_err), 32'd1);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    set_idle();
    tick();
    chk({tag, "_err_clr"}, 32'(misalign_err), 32'd0);
    chk({tag, "_req_clr"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    Rst_n = 1'b0;
    tick();
    tick();
    chk("rst_outs", {stall_m, load_valid_m, misalign_err, bus_err, mem_req, mem_we, mem_be}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_ldata", load_data_m, 32'h0);
    Rst_n = 1'b1;
    tick();

    do_access("sw", 1, 3'b100, 2'b00, 2'b00, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    set_idle();
    tick();
    do_access("lb", 0, 3'b000, 2'b01, 2'b10, 0, 32'h203, 32'h0, 32'h80112233, 3, 0);
    do_access("lbu", 0, 3'b000, 2'b01, 2'b10, 1, 32'h203, 32'h0, 32'h80112233, 3, 0);
    do_access("sh", 1, 3'b010, 2'b00, 2'b00, 0, 32'h102, 32'h0000ABCD, 32'h0, 1, 0);
    set_idle();
    misalign("lh_mis", 0, 3'b000, 2'b01, 2'b01, 32'h101);
    misalign("lw_mis", 0, 3'b000, 2'b01, 2'b00, 32'h102);
    misalign("sw_mis", 1, 3'b100, 2'b00, 2'b00, 32'h203);
    do_access("lw_to", 0, 3'b000, 2'b01, 2'b00, 0, 32'h400, 32'h0, 32'h0, 0, 1);
    do_access("sb_b2b", 1, 3'b001, 2'b00, 2'b00, 0, 32'h3, 32'h00000055, 32'h0, 0, 0);
    do_access("lh_b2b", 0, 3'b000, 2'b01, 2'b01, 0, 32'h2, 32'h0, 32'h80011234, 2, 0);
    do_access("lhu", 0, 3'b000, 2'b01, 2'b01, 1, 32'h0, 32'h0, 32'h1234F00D, 0, 0);
    do_access("lw_sel3", 0, 3'b000, 2'b01, 2'b11, 1, 32'h44, 32'h0, 32'h9ABC0123, 1, 0);
    do_access("st_prio", 1, 3'b100, 2'b01, 2'b10, 0, 32'h48, 32'hCAFEF00D, 32'h0, 0, 0);
    do_access("sb_lane1", 1, 3'b001, 2'b00, 2'b00, 0, 32'h1, 32'h123456A7, 32'h0, 0, 0);

    // memwrite with an invalid store_sel is not an access
    memwrite_m = 1'b1; store_sel_m = 3'b011; result_src_m = 2'b00;
    #1;
    chk("nostore_stall", 32'(stall_m), 32'd0);
    tick();
    chk("nostore_req", {30'h0, mem_req, misalign_err}, 32'd0);
    set_idle();

    // reset in the middle of a WAIT
    memwrite_m = 1'b0; result_src_m = 2'b01; load_sel_m = 2'b00; alu_addr_m = 32'h300;
    tick();
    chk("rw_req", 32'(mem_req), 32'd1);
    tick();
    tick();
    chk("rw_wait", {30'h0, mem_req, stall_m}, 32'd3);
    Rst_n = 1'b0;
    tick();
    chk("rw_outs", {stall_m, load_valid_m, misalign_err, bus_err, mem_req, mem_we, mem_be}, 32'd0);
    chk("rw_addr", mem_addr, 32'h0);
    chk("rw_ldata", load_data_m, 32'h0);
    set_idle();
    Rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0;
    chk("late_ack", {29'h0, mem_req, load_valid_m, stall_m}, 32'd0);
    chk("late_ack_data", load_data_m, 32'h0);
    tick();
    chk("sb_empty", 32'(bus_q.size() + ld_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
